barrel_shifter_pipe: RTL and testbench



---
 rtl/barrel_shifter_pkg.sv | 24 ++
 rtl/barrel_shift_stage.sv | 129 ++++++++++++
 rtl/barrel_shifter_pipe.sv | 96 +++++++++
 tb/tb_barrel_shifter_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
// ============================================================================
// Module   : barrel_shifter_pkg
// Brief    : Op encoding, op type and stage-distance helper for the shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_shifter_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_SLL = 2'd0;
   localparam op_t OP_SRL = 2'd1;
   localparam op_t OP_SRA = 2'd2;
   localparam op_t OP_ROR = 2'd3;

   // Stages are ordered largest distance first.
   function automatic int stage_dist(input int k, input int num_stages);
      return 1 << (num_stages - 1 - k);
   endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_stage.sv
// ============================================================================
// Module   : barrel_shift_stage
// Brief    : One registered mux stage shifting by DIST when its shamt bit is
//            set. Sticky accumulation under BARREL_SHIFTER_PIPE_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_stage
   import barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int DIST  = 1,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               adv,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  op_t                in_op,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
   input  logic               in_sticky,
   output logic               out_sticky,
`endif
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SHAMT_W-1:0] out_shamt,
   output op_t                out_op,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int SEL = $clog2(DIST);
   localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> (WIDTH - DIST);
   localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << (WIDTH - DIST);

   logic [WIDTH-1:0]   shifted;
   logic               valid_d, valid_q;
   logic [WIDTH-1:0]   data_d, data_q;
   logic [SHAMT_W-1:0] shamt_d, shamt_q;
   op_t                op_d, op_q;
   logic [TAG_W-1:0]   tag_d, tag_q;

   always_comb begin
      shifted = in_data;
      if (in_shamt[SEL]) begin
         case (in_op)
            OP_SLL:  shifted = in_data << DIST;
            OP_SRL:  shifted = in_data >> DIST;
            OP_SRA:  shifted = $signed(in_data) >>> DIST;
            default: shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
         endcase
      end
   end

`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
   logic shifted_out;
   logic sticky_d, sticky_q;

   always_comb begin
      shifted_out = 1'b0;
      if (in_shamt[SEL]) begin
         case (in_op)
            OP_SLL:         shifted_out = |(in_data & HI_MASK);
            OP_SRL, OP_SRA: shifted_out = |(in_data & LO_MASK);
            default:        shifted_out = 1'b0;
         endcase
      end
   end

   always_comb begin
      sticky_d = sticky_q;
      if (adv) sticky_d = in_sticky | shifted_out;
   end

   always_ff @(posedge clk) begin
      if (rst) sticky_q <= 1'b0;
      else     sticky_q <= sticky_d;
   end

   assign out_sticky = sticky_q;
`else
   logic [WIDTH-1:0] mask_unused;
   assign mask_unused = LO_MASK | HI_MASK;
`endif

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      tag_d   = tag_q;
      if (adv) begin
         valid_d = in_valid;
         data_d  = shifted;
         shamt_d = in_shamt;
         op_d    = in_op;
         tag_d   = in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         shamt_q <= '0;
         op_q    <= OP_SLL;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_shamt = shamt_q;
   assign out_op    = op_q;
   assign out_tag   = tag_q;

endmodule

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
// Module   : barrel_shifter_pipe
// Brief    : Fully pipelined SLL/SRL/SRA/ROR barrel shifter, one stage per
//            shamt bit, valid/ready stream. Macro BARREL_SHIFTER_PIPE_STICKY_EN
//            adds the out_sticky port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe
   import barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
   ,
   output logic               out_sticky
`endif
);

   localparam int L = SHAMT_W;

   logic               adv;
   logic               stage_valid [0:L];
   logic [WIDTH-1:0]   stage_data  [0:L];
   logic [SHAMT_W-1:0] stage_shamt [0:L];
   op_t                stage_op    [0:L];
   logic [TAG_W-1:0]   stage_tag   [0:L];
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
   logic               stage_sticky [0:L];
   assign stage_sticky[0] = 1'b0;
`endif

   // The whole pipe moves together; bubbles are carried, not collapsed.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign stage_valid[0] = in_valid;
   assign stage_data[0]  = in_data;
   assign stage_shamt[0] = in_shamt;
   assign stage_op[0]    = in_op;
   assign stage_tag[0]   = in_tag;

   for (genvar k = 0; k < L; k++) begin : g_stage
      barrel_shift_stage #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .DIST  (stage_dist(k, L))
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .adv        (adv),
         .in_valid   (stage_valid[k]),
         .in_data    (stage_data[k]),
         .in_shamt   (stage_shamt[k]),
         .in_op      (stage_op[k]),
         .in_tag     (stage_tag[k]),
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
         .in_sticky  (stage_sticky[k]),
         .out_sticky (stage_sticky[k+1]),
`endif
         .out_valid  (stage_valid[k+1]),
         .out_data   (stage_data[k+1]),
         .out_shamt  (stage_shamt[k+1]),
         .out_op     (stage_op[k+1]),
         .out_tag    (stage_tag[k+1])
      );
   end

   logic w_unused;
   assign w_unused = ^{stage_shamt[L], stage_op[L]};

   assign out_valid = stage_valid[L];
   assign out_data  = stage_data[L];
   assign out_tag   = stage_tag[L];
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
   assign out_sticky = stage_sticky[L];
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
// Module   : tb_barrel_shifter_pipe
// Brief    : Self-checking bench for barrel_shifter_pipe (WIDTH=32, TAG_W=4),
//            directed cases plus randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter_pipe;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int L     = 5;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [TAG_W-1:0] tag;
      logic             sticky;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [4:0]       in_shamt = '0;
   logic [1:0]       in_op = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
   logic             out_sticky;
`endif

   int               n_checks = 0;
   int               n_errors = 0;
   exp_t             sb[$];
   logic [WIDTH-1:0] last_data;
   logic [TAG_W-1:0] last_tag;
   logic             last_sticky;
   logic             popped;
   int               n_popped = 0;
   int               n_accepted = 0;

   always #5 clk = ~clk;

   barrel_shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_shamt   (in_shamt),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag)
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      ,
      .out_sticky (out_sticky)
`endif
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model_data(input logic [WIDTH-1:0] d,
                                                   input logic [4:0] s, input logic [1:0] op);
      logic [63:0] t;
      case (op)
         2'd0: return d << s;
         2'd1: return d >> s;
         2'd2: begin t = {{WIDTH{d[WIDTH-1]}}, d} >> s; return t[WIDTH-1:0]; end
         default: begin t = {d, d} >> s; return t[WIDTH-1:0]; end
      endcase
   endfunction

   function automatic logic model_sticky(input logic [WIDTH-1:0] d,
                                         input logic [4:0] s, input logic [1:0] op);
      logic [WIDTH-1:0] m;
      if (s == 0) return 1'b0;
      case (op)
         2'd0: return (d >> (WIDTH - int'(s))) != 0;
         2'd1, 2'd2: begin m = (32'h1 << s) - 1; return (d & m) != 0; end
         default: return 1'b0;
      endcase
   endfunction

   // One cycle: drive after negedge, sample before the next posedge.
   task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] d,
                       input logic [4:0] s, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                       input logic ordy, output logic acc, output logic rdy);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = iv; in_data = d; in_shamt = s; in_op = op; in_tag = tag;
      out_ready = ordy;
      #1;
      rdy = in_ready;
      acc = !r && iv && in_ready;
      popped = 1'b0;
      if (r) begin
         sb.delete();
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               check("out_data", 64'(out_data), 64'(sb[0].data));
               check("out_tag", 64'(out_tag), 64'(sb[0].tag));
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
               check("out_sticky", 64'(out_sticky), 64'(sb[0].sticky));
               last_sticky = out_sticky;
`endif
               if (out_ready) begin
                  last_data = out_data;
                  last_tag  = out_tag;
                  void'(sb.pop_front());
                  popped = 1'b1;
                  n_popped++;
               end
            end
         end
         if (acc) begin
            e.data = model_data(d, s, op);
            e.tag = tag;
            e.sticky = model_sticky(d, s, op);
            sb.push_back(e);
            n_accepted++;
         end
      end
   endtask

   task automatic idle(input logic ordy);
      logic a, r;
      step(1'b0, 1'b0, '0, '0, 2'd0, '0, ordy, a, r);
   endtask

   // Send one beat into an empty pipe and measure cycles until it pops.
   task automatic run_one(input logic [WIDTH-1:0] d, input logic [4:0] s,
                          input logic [1:0] op, input logic [TAG_W-1:0] tag, output int lat);
      logic a, r;
      step(1'b0, 1'b1, d, s, op, tag, 1'b1, a, r);
      check("accept", 64'(a), 64'd1);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1'b1);
         lat++;
         if (popped) break;
      end
   endtask

   initial begin
      int lat;
      logic a, r;
      int idx;
      logic [TAG_W-1:0] tags[$];

      repeat (3) step(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd3, 2'd0, 4'hF, 1'b1, a, r);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);

      run_one(32'h0000_0001, 5'd31, 2'd0, 4'hA, lat);
      check("sll_latency", 64'(lat), 64'(L));
      check("sll_data", 64'(last_data), 64'h8000_0000);
      check("sll_tag", 64'(last_tag), 64'hA);

      run_one(32'h8000_0000, 5'd4, 2'd2, 4'h1, lat);
      check("sra_data", 64'(last_data), 64'hF800_0000);
      run_one(32'h8000_0000, 5'd4, 2'd1, 4'h2, lat);
      check("srl_data", 64'(last_data), 64'h0800_0000);
      run_one(32'h1234_5678, 5'd8, 2'd3, 4'h3, lat);
      check("ror_data", 64'(last_data), 64'h7812_3456);
`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      check("ror_sticky", 64'(last_sticky), 64'd0);
`endif
      for (int op = 0; op < 4; op++) begin
         run_one(32'h1234_5678, 5'd0, 2'(op), 4'(op), lat);
         check("zero_shift", 64'(last_data), 64'h1234_5678);
      end

`ifdef BARREL_SHIFTER_PIPE_STICKY_EN
      run_one(32'h0000_0013, 5'd4, 2'd1, 4'h4, lat);
      check("stk_srl_data", 64'(last_data), 64'h1);
      check("stk_srl_1", 64'(last_sticky), 64'd1);
      run_one(32'h0000_0010, 5'd4, 2'd1, 4'h5, lat);
      check("stk_srl_0", 64'(last_sticky), 64'd0);
      run_one(32'hFFFF_FFFF, 5'd7, 2'd3, 4'h6, lat);
      check("stk_ror_0", 64'(last_sticky), 64'd0);
`endif

      // Backpressure: 8 beats, out_ready low for cycles 6..8.
      idx = 0;
      n_popped = 0;
      for (int c = 0; c < 40; c++) begin
         logic stall;
         stall = (c >= 6 && c < 9);
         step(1'b0, idx < 8, 32'h0000_0100 + 32'(idx), 5'(idx), 2'(idx), 4'(idx), !stall, a, r);
         if (stall) begin
            check("bp_in_ready", 64'(r), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
         end
         if (popped) tags.push_back(last_tag);
         if (a) idx++;
      end
      check("bp_count", 64'(tags.size()), 64'd8);
      for (int i = 0; i < tags.size(); i++) check("bp_order", 64'(tags[i]), 64'(i));

      // Reset mid-flight.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDEAD_BEEF, 5'd1, 2'd1, 4'(9 + i), 1'b1, a, r);
      step(1'b1, 1'b0, '0, '0, 2'd0, '0, 1'b1, a, r);
      idle(1'b1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_out_data", 64'(out_data), 64'd0);
      repeat (8) idle(1'b1);
      run_one(32'h0000_00F0, 5'd4, 2'd1, 4'h5, lat);
      check("post_rst_latency", 64'(lat), 64'(L));
      check("post_rst_data", 64'(last_data), 64'h0000_000F);
      check("post_rst_tag", 64'(last_tag), 64'h5);

      // Randomized traffic.
      n_accepted = 0;
      n_popped = 0;
      for (int c = 0; c < 400; c++) begin
         step(1'b0, $urandom_range(0, 3) != 0, $urandom, 5'($urandom), 2'($urandom),
              4'($urandom), $urandom_range(0, 3) != 0, a, r);
      end
      for (int c = 0; c < 50 && sb.size() != 0; c++) idle(1'b1);
      check("drain_empty", 64'(sb.size()), 64'd0);
      check("rand_count", 64'(n_popped), 64'(n_accepted));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
